uart_ctrl: RTL and testbench

UART_CTRL -- requirements
Module: uart_ctrl

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_fifo.sv | 45 ++++
 rtl/uart_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_uart_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM states, constants and parity helper.
// PARITY states exist only when UART_PARITY_EN is defined.
package uart_pkg;
  localparam int OVERSAMPLE  = 16;
  localparam int START_TICKS = 7;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  // Parity bit that makes the frame even (odd=0) or odd (odd=1).
  function automatic logic par_bit(input logic [7:0] d,
                                   input logic       odd);
    return (^d) ^ odd;
  endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: first-word-fall-through FIFO with occupancy output.
// A write into a full FIFO succeeds only alongside a read.
module uart_fifo #(
  parameter int B = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr,
  input  logic         i_rd,
  input  logic [B-1:0] i_wdata,
  output logic [B-1:0] o_rdata,
  output logic         o_empty,
  output logic         o_full,
  output logic [W:0]   o_level
);
  logic [B-1:0] r_mem [2**W];
  logic [W:0]   r_wp;
  logic [W:0]   r_rp;
  logic         w_do_rd;
  logic         w_do_wr;

  assign o_level = r_wp - r_rp;
  assign o_empty = (r_wp == r_rp);
  assign o_full  = o_level[W];
  assign w_do_rd = i_rd && !o_empty;
  assign w_do_wr = i_wr && (!o_full || w_do_rd);
  assign o_rdata = o_empty ? '0 : r_mem[r_rp[W-1:0]];

  // Read/write pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_wr) r_wp <= r_wp + (W+1)'(1);
      if (w_do_rd) r_rp <= r_rp + (W+1)'(1);
    end
  end

  // Storage array, contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wp[W-1:0]] <= i_wdata;
  end
endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: 16x oversampled UART with TX/RX FIFOs and sticky errors.
// Define UART_PARITY_EN to build in the parity bit and parity_err.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int FIFO_AW = 2,
  parameter int DIV_W   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divisor,
  input  logic             par_en,
  input  logic             par_odd,
  input  logic             stop2,
  input  logic             tx_en,
  input  logic             rx,
  input  logic             w_uart,
  input  logic [7:0]       w_data,
  input  logic             r_uart,
  input  logic             err_clr,
  output logic             tx,
  output logic [7:0]       r_data,
  output logic             rx_empty,
  output logic             tx_full,
  output logic [FIFO_AW:0] rx_level,
  output logic [FIFO_AW:0] tx_level,
  output logic             tx_busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun_err
);
  localparam logic [4:0] T_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] T_LAST2 = 5'(2 * OVERSAMPLE - 1);
  localparam logic [3:0] R_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] R_SMP   = 4'(START_TICKS - 1);
  localparam logic [2:0] B_LAST  = 3'(DBIT - 1);

  logic [DIV_W-1:0] r_bcnt;
  logic             w_tick;
  logic [1:0]       r_rx_s;
  logic             w_rxd;

  tx_state_t        r_tx_st, w_tx_nst;
  logic [4:0]       r_tx_tc, w_tx_ntc;
  logic [2:0]       r_tx_bc, w_tx_nbc;
  logic [DBIT-1:0]  r_tx_sh, w_tx_nsh;
  logic             r_tx_s2;
  logic             w_tx_load, w_tx_go, w_tx_o;
  logic [DBIT-1:0]  w_tx_head;
  logic             w_tx_empty;

  rx_state_t        r_rx_st, w_rx_nst;
  logic [3:0]       r_rx_tc, w_rx_ntc;
  logic [2:0]       r_rx_bc, w_rx_nbc;
  logic [DBIT-1:0]  r_rx_sh, w_rx_nsh;
  logic             w_rx_wr, w_ferr, w_ovr;
  logic [DBIT-1:0]  w_rx_head;
  logic             w_rx_full;

`ifdef UART_PARITY_EN
  logic r_tx_pen, r_tx_pb;
  logic r_rx_pen, r_rx_odd, r_rx_pb, w_rx_npb;
  logic w_perr, r_perr;
  assign parity_err = r_perr;
`else
  logic w_unused;
  assign w_unused   = ^{par_en, par_odd};
  assign parity_err = 1'b0;
`endif

  assign w_tick  = (r_bcnt >= divisor);
  assign w_rxd   = r_rx_s[1];
  assign w_tx_go = tx_en && !w_tx_empty;
  assign tx      = w_tx_o;
  assign tx_busy = (r_tx_st != TX_IDLE);
  assign r_data  = 8'(w_rx_head);
  assign w_ovr   = w_rx_wr && w_rx_full && !r_uart;

  // Oversample tick generator, wraps at (or above) divisor
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_bcnt <= '0;
    else     r_bcnt <= w_tick ? '0 : r_bcnt + DIV_W'(1);
  end

  // Two-flop synchroniser for the asynchronous rx line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rx_s <= 2'b11;
    else     r_rx_s <= {r_rx_s[0], rx};
  end

  uart_fifo #(.B(DBIT), .W(FIFO_AW)) u_txf (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_uart),
    .i_rd    (w_tx_load),
    .i_wdata (w_data[DBIT-1:0]),
    .o_rdata (w_tx_head),
    .o_empty (w_tx_empty),
    .o_full  (tx_full),
    .o_level (tx_level)
  );

  uart_fifo #(.B(DBIT), .W(FIFO_AW)) u_rxf (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_rx_wr),
    .i_rd    (r_uart),
    .i_wdata (r_rx_sh),
    .o_rdata (w_rx_head),
    .o_empty (rx_empty),
    .o_full  (w_rx_full),
    .o_level (rx_level)
  );

  // TX next state; frames start tick-aligned so every bit is 16 ticks
  always_comb begin
    w_tx_nst  = r_tx_st;
    w_tx_ntc  = r_tx_tc;
    w_tx_nbc  = r_tx_bc;
    w_tx_nsh  = r_tx_sh;
    w_tx_load = 1'b0;
    w_tx_o    = 1'b1;
    unique case (r_tx_st)
      TX_IDLE: if (w_tick && w_tx_go) w_tx_load = 1'b1;
      TX_START: begin
        w_tx_o = 1'b0;
        if (w_tick) begin
          if (r_tx_tc == T_LAST) begin
            w_tx_nst = TX_DATA;
            w_tx_ntc = '0;
            w_tx_nbc = '0;
          end else w_tx_ntc = r_tx_tc + 5'd1;
        end
      end
      TX_DATA: begin
        w_tx_o = r_tx_sh[0];
        if (w_tick) begin
          if (r_tx_tc == T_LAST) begin
            w_tx_ntc = '0;
            w_tx_nsh = r_tx_sh >> 1;
            if (r_tx_bc == B_LAST) begin
`ifdef UART_PARITY_EN
              w_tx_nst = r_tx_pen ? TX_PARITY : TX_STOP;
`else
              w_tx_nst = TX_STOP;
`endif
            end else w_tx_nbc = r_tx_bc + 3'd1;
          end else w_tx_ntc = r_tx_tc + 5'd1;
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        w_tx_o = r_tx_pb;
        if (w_tick) begin
          if (r_tx_tc == T_LAST) begin
            w_tx_nst = TX_STOP;
            w_tx_ntc = '0;
          end else w_tx_ntc = r_tx_tc + 5'd1;
        end
      end
`endif
      TX_STOP: begin
        if (w_tick) begin
          if (r_tx_tc == (r_tx_s2 ? T_LAST2 : T_LAST)) begin
            if (w_tx_go) w_tx_load = 1'b1;
            else         w_tx_nst  = TX_IDLE;
          end else w_tx_ntc = r_tx_tc + 5'd1;
        end
      end
      default: ;
    endcase
    if (w_tx_load) begin
      w_tx_nst = TX_START;
      w_tx_ntc = '0;
      w_tx_nsh = w_tx_head;
    end
  end

  // TX state register; frame options latched as the byte is popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_st <= TX_IDLE;
      r_tx_tc <= '0;
      r_tx_bc <= '0;
      r_tx_sh <= '0;
      r_tx_s2 <= 1'b0;
`ifdef UART_PARITY_EN
      r_tx_pen <= 1'b0;
      r_tx_pb  <= 1'b0;
`endif
    end else begin
      r_tx_st <= w_tx_nst;
      r_tx_tc <= w_tx_ntc;
      r_tx_bc <= w_tx_nbc;
      r_tx_sh <= w_tx_nsh;
      if (w_tx_load) begin
        r_tx_s2 <= stop2;
`ifdef UART_PARITY_EN
        r_tx_pen <= par_en;
        r_tx_pb  <= par_bit(8'(w_tx_head), par_odd);
`endif
      end
    end
  end

  // RX next state; start bit re-checked to reject glitches
  always_comb begin
    w_rx_nst = r_rx_st;
    w_rx_ntc = r_rx_tc;
    w_rx_nbc = r_rx_bc;
    w_rx_nsh = r_rx_sh;
    w_rx_wr  = 1'b0;
    w_ferr   = 1'b0;
`ifdef UART_PARITY_EN
    w_rx_npb = r_rx_pb;
    w_perr   = 1'b0;
`endif
    unique case (r_rx_st)
      RX_IDLE: begin
        if (!w_rxd) begin
          w_rx_nst = RX_START;
          w_rx_ntc = '0;
        end
      end
      RX_START: begin
        if (w_tick) begin
          if (r_rx_tc == R_SMP) begin
            w_rx_nst = w_rxd ? RX_IDLE : RX_DATA;
            w_rx_ntc = '0;
            w_rx_nbc = '0;
          end else w_rx_ntc = r_rx_tc + 4'd1;
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          if (r_rx_tc == R_LAST) begin
            w_rx_ntc = '0;
            w_rx_nsh = {w_rxd, r_rx_sh[DBIT-1:1]};
            if (r_rx_bc == B_LAST) begin
`ifdef UART_PARITY_EN
              w_rx_nst = r_rx_pen ? RX_PARITY : RX_STOP;
`else
              w_rx_nst = RX_STOP;
`endif
            end else w_rx_nbc = r_rx_bc + 3'd1;
          end else w_rx_ntc = r_rx_tc + 4'd1;
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (w_tick) begin
          if (r_rx_tc == R_LAST) begin
            w_rx_ntc = '0;
            w_rx_npb = w_rxd;
            w_rx_nst = RX_STOP;
          end else w_rx_ntc = r_rx_tc + 4'd1;
        end
      end
`endif
      RX_STOP: begin
        if (w_tick) begin
          if (r_rx_tc == R_LAST) begin
            w_rx_wr  = 1'b1;
            w_ferr   = !w_rxd;
`ifdef UART_PARITY_EN
            w_perr   = r_rx_pen &&
              (r_rx_pb != par_bit(8'(r_rx_sh), r_rx_odd));
`endif
            w_rx_nst = RX_IDLE;
          end else w_rx_ntc = r_rx_tc + 4'd1;
        end
      end
      default: ;
    endcase
  end

  // RX state register; parity options follow the line while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_st <= RX_IDLE;
      r_rx_tc <= '0;
      r_rx_bc <= '0;
      r_rx_sh <= '0;
`ifdef UART_PARITY_EN
      r_rx_pen <= 1'b0;
      r_rx_odd <= 1'b0;
      r_rx_pb  <= 1'b0;
`endif
    end else begin
      r_rx_st <= w_rx_nst;
      r_rx_tc <= w_rx_ntc;
      r_rx_bc <= w_rx_nbc;
      r_rx_sh <= w_rx_nsh;
`ifdef UART_PARITY_EN
      r_rx_pb <= w_rx_npb;
      if (r_rx_st == RX_IDLE) begin
        r_rx_pen <= par_en;
        r_rx_odd <= par_odd;
      end
`endif
    end
  end

  // Sticky error flags; a new error beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_PARITY_EN
      r_perr      <= 1'b0;
`endif
    end else begin
      if (w_ferr)       frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (w_ovr)        overrun_err <= 1'b1;
      else if (err_clr) overrun_err <= 1'b0;
`ifdef UART_PARITY_EN
      if (w_perr)       r_perr <= 1'b1;
      else if (err_clr) r_perr <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed + randomized checks of uart_ctrl.
// Parity expectations follow UART_PARITY_EN when it is defined.
module tb_uart_ctrl;
`ifdef UART_PARITY_EN
  localparam bit PAR_HW = 1'b1;
`else
  localparam bit PAR_HW = 1'b0;
`endif
  localparam int BITC = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] divisor = 11'd3;
  logic        par_en = 0, par_odd = 0, stop2 = 0;
  logic        tx_en = 0, w_uart = 0, r_uart = 0;
  logic        err_clr = 0;
  logic [7:0]  w_data = '0;
  logic        rx_drv = 1'b1, loop = 1'b0;
  logic        rx_in;
  logic        tx, rx_empty, tx_full, tx_busy;
  logic        frame_err, parity_err, overrun_err;
  logic [7:0]  r_data;
  logic [2:0]  rx_level, tx_level;
  int          n_vec = 0, n_fail = 0;

  assign rx_in = loop ? tx : rx_drv;

  uart_ctrl #(.DBIT(8), .FIFO_AW(2), .DIV_W(11)) dut (
    .clk(clk), .rst(rst), .divisor(divisor),
    .par_en(par_en), .par_odd(par_odd), .stop2(stop2),
    .tx_en(tx_en), .rx(rx_in), .w_uart(w_uart),
    .w_data(w_data), .r_uart(r_uart), .err_clr(err_clr),
    .tx(tx), .r_data(r_data), .rx_empty(rx_empty),
    .tx_full(tx_full), .rx_level(rx_level),
    .tx_level(tx_level), .tx_busy(tx_busy),
    .frame_err(frame_err), .parity_err(parity_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    w_uart = 1'b1;
    w_data = b;
    @(negedge clk);
    w_uart = 1'b0;
  endtask

  task automatic pop();
    r_uart = 1'b1;
    @(negedge clk);
    r_uart = 1'b0;
  endtask

  task automatic clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) if (!rx_empty) pop();
  endtask

  // Drive one serial frame onto rx at 64 clk per bit
  task automatic send_rx(input logic [7:0] d, input bit pen,
                         input bit pv, input bit sv);
    rx_drv = 1'b0;
    tick(BITC);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      tick(BITC);
    end
    if (pen) begin
      rx_drv = pv;
      tick(BITC);
    end
    rx_drv = sv;
    tick(BITC);
    rx_drv = 1'b1;
  endtask

  // Expected line levels of a frame, checked cycle by cycle
  task automatic tx_frame(input logic [7:0] b, input bit pen,
                          input bit po, input bit s2,
                          input int blen, input bit chained,
                          input bit disturb);
    bit seq[$];
    int n, ok;
    seq.push_back(1'b0);
    for (int i = 0; i < 8; i++) seq.push_back(b[i]);
    if (pen) seq.push_back((^b) ^ po);
    seq.push_back(1'b1);
    if (s2) seq.push_back(1'b1);
    n = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("tx_start_seen", tx, 0);
    if (chained) chk("tx_gap", n, 0);
    for (int k = 0; k < seq.size(); k++) begin
      ok = 0;
      for (int c = 0; c < blen; c++) begin
        if (k > 0 || c > 0) @(negedge clk);
        if (tx === seq[k]) ok++;
        if (disturb && k == 1 && c == 0) begin
          tx_en = 1'b0;
          par_en = ~par_en;
          par_odd = ~par_odd;
          stop2 = ~stop2;
        end
      end
      chk($sformatf("tx_bit%0d_%02h", k, b), ok, blen);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] q[$];
    int d, n;
    bit pe, po, s2;

    tick(3);
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_oerr", overrun_err, 0);
    rst = 1'b0;
    tick(2);

    // 8N1 0xA5 at divisor 3
    tx_en = 1'b1;
    push(8'hA5);
    tx_frame(8'hA5, 0, 0, 0, BITC, 0, 0);
    tick(2);
    chk("a5_idle", tx_busy, 0);

    // Random TX frames, random divisor and format
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      d = $urandom_range(0, 4);
      pe = 1'($urandom);
      po = 1'($urandom);
      s2 = 1'($urandom);
      divisor = 11'(d);
      par_en = pe;
      par_odd = po;
      stop2 = s2;
      push(b);
      tx_frame(b, pe && PAR_HW, po, s2, 16 * (d + 1), 0, k == 2);
      tick(2);
      chk("rnd_tx_idle", tx_busy, 0);
      tx_en = 1'b1;
    end
    divisor = 11'd3;
    par_en = 0;
    par_odd = 0;
    stop2 = 0;
    tick(8);

    // Frame 0x03 with a wrong (odd) even-parity bit
    par_en = 1'b1;
    send_rx(8'h03, PAR_HW, 1'b1, 1'b1);
    tick(BITC);
    chk("par_rdata", r_data, 8'h03);
    chk("par_err_set", parity_err, PAR_HW);
    clr();
    chk("par_err_clr", parity_err, 0);
    pop();
    chk("par_popped", rx_empty, 1);

    // Random RX frames with correct parity
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      po = 1'($urandom);
      par_odd = po;
      send_rx(b, PAR_HW, (^b) ^ po, 1'b1);
      tick(BITC);
      chk("rnd_rx_data", r_data, b);
      chk("rnd_rx_perr", parity_err, 0);
      chk("rnd_rx_ferr", frame_err, 0);
      pop();
    end
    par_en = 1'b0;
    par_odd = 1'b0;

    // Frame 0x5A with a low stop bit
    send_rx(8'h5A, 0, 0, 0);
    tick(2);
    chk("ferr_set", frame_err, 1);
    chk("ferr_level", rx_level, 1);
    chk("ferr_rdata", r_data, 8'h5A);
    tick(1000);
    drain();
    clr();
    chk("ferr_clr", frame_err, 0);
    chk("ferr_drained", rx_empty, 1);

    // Overrun: five frames into a four-deep FIFO
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 0, 0, 1);
    tick(BITC);
    chk("ovr_set", overrun_err, 1);
    chk("ovr_level", rx_level, 4);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovr_pop%0d", i), r_data, i);
      pop();
    end
    chk("ovr_empty", rx_empty, 1);
    clr();
    chk("ovr_clr", overrun_err, 0);

    // Loopback, stop2, TX FIFO filled while disabled
    tx_en = 1'b0;
    stop2 = 1'b1;
    q = '{8'h00, 8'hFF, 8'h81, 8'($urandom)};
    foreach (q[i]) push(q[i]);
    push(8'($urandom));
    chk("txf_level", tx_level, 4);
    chk("txf_full", tx_full, 1);
    chk("txf_held", tx_busy, 0);
    loop = 1'b1;
    tx_en = 1'b1;
    foreach (q[i]) tx_frame(q[i], 0, 0, 1, BITC, i > 0, 0);
    tick(4);
    chk("lb_idle", tx_busy, 0);
    chk("lb_rx_level", rx_level, 4);
    foreach (q[i]) begin
      chk($sformatf("lb_rx%0d", i), r_data, q[i]);
      pop();
    end
    chk("lb_oerr", overrun_err, 0);
    loop = 1'b0;
    stop2 = 1'b0;

    // Reset in the middle of a frame
    push(8'h00);
    push(8'h00);
    n = 0;
    while (tx !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tick(BITC + 20);
    chk("mid_tx_low", tx, 0);
    chk("mid_busy", tx_busy, 1);
    chk("mid_level", tx_level, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_busy", tx_busy, 0);
    chk("rst_mid_level", tx_level, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(4);

    // Short rx glitch is rejected
    rx_drv = 1'b0;
    tick(12);
    rx_drv = 1'b1;
    tick(1000);
    chk("glitch_empty", rx_empty, 1);
    chk("glitch_level", rx_level, 0);
    chk("glitch_ferr", frame_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_fail);
    $finish;
  end
endmodule
